// File: rtl/left_rotate_seq.sv
// Sequential 32-bit left rotator: loads B, rotates left A[4:0] times, pulses Done.
// Optional macro LROT_FAST_EN enables 4-bit steps while the remaining count is >= 4.
module left_rotate_seq (
   input  logic        clk,
   input  logic        clr,
   input  logic        Start,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic [31:0] Result,
   output logic        Busy,
   output logic        Done,
   output logic [1:0]  o_dbg_state
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ROTATE = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [31:0] r_result;
   logic [31:0] w_result_nxt;
   logic [4:0]  r_count;
   logic [4:0]  w_count_nxt;
   logic [4:0]  w_count_dec;
   logic [31:0] w_rot;
   logic        w_unused;

   // Only the rotate amount modulo 32 matters.
   assign w_unused = ^A[31:5];

   always_ff @(posedge clk) begin
      if (!clr) begin
         r_state  <= ST_IDLE;
         r_result <= 32'd0;
         r_count  <= 5'd0;
      end else begin
         r_state  <= w_state_nxt;
         r_result <= w_result_nxt;
         r_count  <= w_count_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_result_nxt = r_result;
      w_count_nxt  = r_count;
      w_rot        = {r_result[30:0], r_result[31]};
      w_count_dec  = r_count - 5'd1;
`ifdef LROT_FAST_EN
      if (r_count >= 5'd4) begin
         w_rot       = {r_result[27:0], r_result[31:28]};
         w_count_dec = r_count - 5'd4;
      end
`endif
      // The last rotate step goes straight to DONE so Done lands in cycle M+1.
      case (r_state)
         ST_IDLE: begin
            if (Start) begin
               w_result_nxt = B;
               w_count_nxt  = A[4:0];
               w_state_nxt  = (A[4:0] == 5'd0) ? ST_DONE : ST_ROTATE;
            end
         end
         ST_ROTATE: begin
            if (r_count != 5'd0) begin
               w_result_nxt = w_rot;
               w_count_nxt  = w_count_dec;
               if (w_count_dec == 5'd0) begin
                  w_state_nxt = ST_DONE;
               end
            end else begin
               w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   assign Result      = r_result;
   assign Busy        = (r_state != ST_IDLE);
   assign Done        = (r_state == ST_DONE);
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_left_rotate_seq.sv
// Directed self-checking bench for left_rotate_seq; expected latencies follow LROT_FAST_EN.
module tb_left_rotate_seq;

   logic        clk;
   logic        clr;
   logic        start;
   logic [31:0] a;
   logic [31:0] b;
   logic [31:0] result;
   logic        busy;
   logic        done;
   logic [1:0]  dbg_state;

   int checks;
   int errors;

   left_rotate_seq dut (
      .clk         (clk),
      .clr         (clr),
      .Start       (start),
      .A           (a),
      .B           (b),
      .Result      (result),
      .Busy        (busy),
      .Done        (done),
      .o_dbg_state (dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Pulse Start with (a_in, b_in), then count cycles until Done.
   task automatic run_op(input string tag, input logic [31:0] a_in, input logic [31:0] b_in,
                         input logic [31:0] exp_res, input int exp_lat);
      int cyc;
      start = 1'b1;
      a     = a_in;
      b     = b_in;
      step();
      start = 1'b0;
      a     = $urandom;
      b     = $urandom;
      cyc   = 1;
      while (done !== 1'b1 && cyc < 60) begin
         step();
         cyc++;
      end
      check({tag, "_done_seen"}, {31'd0, done}, 32'd1);
      check({tag, "_latency"}, cyc, exp_lat);
      check({tag, "_result"}, result, exp_res);
      step();
      check({tag, "_done_drop"}, {31'd0, done}, 32'd0);
      check({tag, "_busy_drop"}, {31'd0, busy}, 32'd0);
      check({tag, "_result_hold"}, result, exp_res);
   endtask

   initial begin
      int cyc;
      int done_seen;
      int first_done;
      int last_done;
      checks = 0;
      errors = 0;
      clr    = 1'b0;
      start  = 1'b0;
      a      = 32'd0;
      b      = 32'd0;

      // Reset state
      step();
      step();
      check("rst_result", result, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_state", {30'd0, dbg_state}, 32'd0);

      // Start while in reset is ignored
      start = 1'b1;
      a     = 32'd3;
      b     = 32'hFFFF_0000;
      step();
      start = 1'b0;
      clr   = 1'b1;
      step();
      check("rst_start_busy", {31'd0, busy}, 32'd0);
      check("rst_start_result", result, 32'd0);

      // A=1, B=0x80000001: Busy cycles 1-2, Done cycle 2, Result=3
      start = 1'b1;
      a     = 32'd1;
      b     = 32'h8000_0001;
      step();
      start = 1'b0;
      check("v1_c1_busy", {31'd0, busy}, 32'd1);
      check("v1_c1_done", {31'd0, done}, 32'd0);
      step();
      check("v1_c2_busy", {31'd0, busy}, 32'd1);
      check("v1_c2_done", {31'd0, done}, 32'd1);
      check("v1_c2_result", result, 32'h0000_0003);
      step();
      check("v1_c3_busy", {31'd0, busy}, 32'd0);
      check("v1_c3_done", {31'd0, done}, 32'd0);

      // Idle with Start=0 keeps Result
      b = 32'hDEAD_BEEF;
      step();
      step();
      check("idle_hold", result, 32'h0000_0003);

      run_op("a32", 32'd32, 32'h1234_5678, 32'h1234_5678, 1);
`ifdef LROT_FAST_EN
      run_op("a31", 32'd31, 32'h0000_0001, 32'h8000_0000, 11);
      run_op("a5", 32'd5, 32'hF000_000F, 32'h0000_01FE, 3);
      run_op("a4", 32'd4, 32'h1234_5678, 32'h2345_6781, 2);
      run_op("a36", 32'd36, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 2);
`else
      run_op("a31", 32'd31, 32'h0000_0001, 32'h8000_0000, 32);
      run_op("a5", 32'd5, 32'hF000_000F, 32'h0000_01FE, 6);
      run_op("a4", 32'd4, 32'h1234_5678, 32'h2345_6781, 5);
      run_op("a36", 32'd36, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 5);
`endif
      run_op("ahi", 32'hFFFF_FFE3, 32'h8000_0000, 32'h0000_0004, 4);

      // A=8, B=0xFF with a second Start in cycle 3 that must be ignored
      start = 1'b1;
      a     = 32'd8;
      b     = 32'h0000_00FF;
      step();
      start = 1'b0;
      cyc   = 1;
      while (done !== 1'b1 && cyc < 60) begin
         if (cyc == 3) begin
            start = 1'b1;
            a     = 32'd1;
            b     = 32'd0;
         end else begin
            start = 1'b0;
         end
         step();
         cyc++;
      end
      start = 1'b0;
`ifdef LROT_FAST_EN
      check("ign_latency", cyc, 32'd3);
`else
      check("ign_latency", cyc, 32'd9);
`endif
      check("ign_result", result, 32'h0000_FF00);
      step();
      check("ign_no_queue_busy", {31'd0, busy}, 32'd0);

      // A=20 aborted by clr=0 in cycle 5
      start = 1'b1;
      a     = 32'd20;
      b     = 32'hCAFE_F00D;
      step();
      start = 1'b0;
      step();
      step();
      step();
      step();
      clr = 1'b0;
      step();
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_result", result, 32'd0);
      check("abort_done", {31'd0, done}, 32'd0);
      clr       = 1'b1;
      done_seen = 0;
      for (int i = 0; i < 30; i++) begin
         step();
         if (done === 1'b1) done_seen++;
      end
      check("abort_no_done", done_seen, 32'd0);

      // Start held high, A=2, B=1: Done every 4 cycles, Result=4
      start      = 1'b1;
      a          = 32'd2;
      b          = 32'h0000_0001;
      first_done = 0;
      last_done  = 0;
      done_seen  = 0;
      for (int i = 1; i <= 13; i++) begin
         step();
         if (done === 1'b1) begin
            done_seen++;
            check("held_result", result, 32'h0000_0004);
            if (done_seen == 1) first_done = i;
            else check("held_period", i - last_done, 32'd4);
            last_done = i;
         end
      end
      start = 1'b0;
      check("held_first_done", first_done, 32'd3);
      check("held_count", done_seen, 32'd3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

endmodule
